// File: rtl/deinterleaver_accum_pkg.sv
// Shared types and width helpers for the deinterleaver accumulator.
package deinterleaver_accum_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Bits of sweepstart chunk (rotation amount within one group of z neurons)
  function automatic int lpz_of(input int p, input int z);
    return (p == z) ? 1 : $clog2(p / z);
  endfunction

  // Beats per pass
  function automatic int cpc_of(input int p, input int fo, input int z);
    return (p * fo) / z;
  endfunction

  // Accumulator width: fo contributions per neuron plus a sign guard bit
  function automatic int aw_of(input int w, input int fo);
    return w + $clog2(fo) + 1;
  endfunction

  // Counter/index width that never collapses to zero bits
  function automatic int bits_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/deinterleaver_addr.sv
// Combinational target-neuron computation for one beat of z lanes.
module deinterleaver_addr
  import deinterleaver_accum_pkg::*;
#(
  parameter int p  = 32,
  parameter int fo = 2,
  parameter int z  = 8,
  localparam int LPZ = lpz_of(p, z),
  localparam int CPC = cpc_of(p, fo, z),
  localparam int CW  = bits_of(CPC),
  localparam int NW  = bits_of(p),
  localparam int NCH = fo * z
) (
  input  logic [CW-1:0]      cyc,
  input  logic [NCH*LPZ-1:0] chunk,
  output logic [z*NW-1:0]    idx
);

  localparam int unsigned PZ = p / z;

  // Lane g always lands in column g; only the row t is rotated by the chunk.
  always_comb begin
    int unsigned s;
    int unsigned sel;
    int unsigned rot;
    int unsigned t;
    s   = 0;
    sel = 0;
    rot = 0;
    t   = 0;
    idx = '0;
    for (int unsigned g = 0; g < z; g++) begin
      s   = 32'(cyc) >> LPZ;
      rot = 32'(cyc) % PZ;
      if (PZ == 1) begin
        t = 0;
      end else begin
        sel = s * z + g;
        t   = (32'(chunk[sel*LPZ +: LPZ]) + rot) % PZ;
      end
      idx[g*NW +: NW] = NW'(t * z + g);
    end
  end

endmodule

// File: rtl/deinterleaver_accum.sv
// Scatter-accumulates z-lane beats into p neuron sums using a loaded
// sweepstart rotation table, then presents all sums until consumed.
module deinterleaver_accum
  import deinterleaver_accum_pkg::*;
#(
  parameter int p  = 32,
  parameter int fo = 2,
  parameter int z  = 8,
  parameter int W  = 16,
  localparam int LPZ = lpz_of(p, z),
  localparam int CPC = cpc_of(p, fo, z),
  localparam int AW  = aw_of(W, fo)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ss_valid,
  input  logic [LPZ-1:0]  ss_data,
  output logic            ss_done,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [z*W-1:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [p*AW-1:0] out_data
);

  localparam int CW  = bits_of(CPC);
  localparam int NW  = bits_of(p);
  localparam int NCH = fo * z;
  localparam int KW  = bits_of(NCH);

  state_t                state;
  logic [KW-1:0]         k;
  logic [CW-1:0]         cyc;
  logic [NCH*LPZ-1:0]    chunk;
  logic signed [AW-1:0]  acc     [p];
  logic signed [AW-1:0]  acc_nxt [p];
  logic [z*NW-1:0]       idx;
  logic [W-1:0]          lane;

  deinterleaver_addr #(
    .p  (p),
    .fo (fo),
    .z  (z)
  ) u_addr (
    .cyc   (cyc),
    .chunk (chunk),
    .idx   (idx)
  );

  // Add each sign-extended lane into its target neuron (targets are distinct)
  always_comb begin
    lane = '0;
    for (int unsigned n = 0; n < p; n++) begin
      acc_nxt[n] = acc[n];
    end
    for (int unsigned g = 0; g < z; g++) begin
      lane = in_data[g*W +: W];
      acc_nxt[idx[g*NW +: NW]] = acc_nxt[idx[g*NW +: NW]]
                                 + {{(AW-W){lane[W-1]}}, lane};
    end
  end

  // Pack accumulators onto the output bus
  always_comb begin
    out_data = '0;
    for (int unsigned n = 0; n < p; n++) begin
      out_data[n*AW +: AW] = acc[n];
    end
  end

  // Control FSM: load rotation table, accumulate one pass, hold for drain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LOAD;
      k         <= '0;
      cyc       <= '0;
      chunk     <= '0;
      ss_done   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      for (int unsigned n = 0; n < p; n++) begin
        acc[n] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (ss_valid) begin
            chunk[k*LPZ +: LPZ] <= ss_data;
            if (k == KW'(NCH - 1)) begin
              k        <= '0;
              ss_done  <= 1'b1;
              in_ready <= 1'b1;
              state    <= ACCUM;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            for (int unsigned n = 0; n < p; n++) begin
              acc[n] <= acc_nxt[n];
            end
            if (cyc == CW'(CPC - 1)) begin
              cyc       <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= DRAIN;
            end else begin
              cyc <= cyc + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            for (int unsigned n = 0; n < p; n++) begin
              acc[n] <= '0;
            end
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule
